// File: rtl/apb_slave_regfile.sv
// APB completer with a DEPTH-word register file and programmable wait states.
// Define APB_SLV_ERR_EN to flag illegal accesses on pslverr.
module apb_slave_regfile #(
  parameter int                ADDR_W      = 8,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 16,
  parameter int                WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] ID_VAL      = 32'hA5B0_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  localparam int         IW      = ADDR_W - 2;
  localparam int         MW      = $clog2(DEPTH);
  localparam logic [IW:0] DEPTH_C = DEPTH[IW:0];
  localparam logic [3:0] WAIT_C  = 4'(WAIT_CYCLES);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              wok_q;
  logic [MW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [IW-1:0]     idx;
  logic              oor;
  logic              ro;
  logic              setup;
  logic              access;
  logic              err_d;
  logic              unused_lo;

  assign idx       = paddr[ADDR_W-1:2];
  assign oor       = {1'b0, idx} >= DEPTH_C;
  assign ro        = (idx == '0);
  assign setup     = psel & ~penable;
  assign access    = psel & penable;
  assign unused_lo = ^paddr[1:0];

`ifdef APB_SLV_ERR_EN
  assign err_d = pwrite ? (ro | oor) : oor;
`else
  assign err_d = 1'b0;
`endif

  assign pready  = rst_n & (state_q == S_WAIT)
                 & (cnt_q == '0) & access;
  assign prdata  = pready ? rdata_q : '0;
  assign pslverr = pready & err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wok_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (setup) begin
            state_q <= S_WAIT;
            cnt_q   <= WAIT_C;
            wok_q   <= pwrite & ~ro & ~oor;
            idx_q   <= idx[MW-1:0];
            wdata_q <= pwdata;
            err_q   <= err_d;
            // read data is captured at setup and held through completion
            rdata_q <= ro  ? ID_VAL :
                       oor ? '0     : mem_q[idx[MW-1:0]];
          end
        end
        S_WAIT: begin
          if (!psel) begin
            state_q <= S_IDLE;
          end else if (penable) begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - 4'd1;
            end else begin
              state_q <= S_IDLE;
              if (wok_q) begin
                mem_q[idx_q] <= wdata_q;
              end
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: two instances (1 and 0 wait states)
// checked against a queue of expected responses and a small register model.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA5B0_0001;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        psel    = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite  = 1'b0;
  logic [7:0]  paddr   = '0;
  logic [31:0] pwdata  = '0;
  logic        sel     = 1'b0;

  logic        rdy_a, rdy_b, err_a, err_b;
  logic [31:0] rd_a, rd_b;
  logic        rdy, err;
  logic [31:0] rd;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chkd;
    int          lat;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl [2][16];

  always #5 clk = ~clk;

  assign rdy = sel ? rdy_b : rdy_a;
  assign err = sel ? err_b : err_a;
  assign rd  = sel ? rd_b  : rd_a;

  apb_slave_regfile #(.WAIT_CYCLES(1)) u_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .psel   (psel & ~sel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .pready (rdy_a),
    .prdata (rd_a),
    .pslverr(err_a)
  );

  apb_slave_regfile #(.WAIT_CYCLES(0)) u_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .psel   (psel & sel),
    .penable(penable),
    .pwrite (pwrite),
    .paddr  (paddr),
    .pwdata (pwdata),
    .pready (rdy_b),
    .prdata (rd_b),
    .pslverr(err_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        mdl[s][i] = '0;
  endtask

  task automatic idle();
    @(negedge clk);
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  // one full transfer; address/data are scrambled during access
  task automatic xfer(input logic s, input logic w,
                      input logic [7:0] a, input logic [31:0] d);
    exp_t e;
    int   idx;
    logic ro, oor;
    int   n;
    idx    = int'(a[7:2]);
    ro     = (idx == 0);
    oor    = (idx >= 16);
    e.data = ro ? ID : (oor ? 32'h0 : mdl[s][idx]);
    e.chkd = !w;
`ifdef APB_SLV_ERR_EN
    e.err  = w ? (ro | oor) : oor;
`else
    e.err  = 1'b0;
`endif
    e.lat  = s ? 1 : 2;
    q.push_back(e);
    if (w && !ro && !oor) mdl[s][idx] = d;
    @(negedge clk);
    sel     = s;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = w;
    paddr   = a;
    pwdata  = d;
    #1;
    chk("setup_rdy", {31'b0, rdy}, 32'd0);
    chk("setup_rd", rd, 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      penable = 1'b1;
      paddr   = 8'($urandom);
      pwdata  = $urandom;
      #1;
      n++;
    end while (!rdy && n < 20);
    e = q.pop_front();
    chk("lat", n, e.lat);
    if (e.chkd) chk("rdata", rd, e.data);
    chk("err", {31'b0, err}, {31'b0, e.err});
  endtask

  initial begin
    clr_model();
    repeat (2) @(negedge clk);
    chk("rst_rdy_a", {31'b0, rdy_a}, 32'd0);
    chk("rst_rdy_b", {31'b0, rdy_b}, 32'd0);
    chk("rst_rd_a", rd_a, 32'd0);
    chk("rst_err_a", {31'b0, err_a}, 32'd0);
    rst_n = 1'b1;

    xfer(1'b0, 1'b1, 8'h0C, 32'hDEADBEEF);
    xfer(1'b0, 1'b0, 8'h0C, 32'h0);

    xfer(1'b1, 1'b0, 8'h00, 32'h0);
    xfer(1'b1, 1'b1, 8'h00, 32'hFFFF_FFFF);
    xfer(1'b1, 1'b0, 8'h00, 32'h0);

    xfer(1'b0, 1'b1, 8'h40, 32'h5555_AAAA);
    xfer(1'b0, 1'b0, 8'h40, 32'h0);
    xfer(1'b1, 1'b1, 8'h40, 32'h5555_AAAA);
    xfer(1'b1, 1'b0, 8'h40, 32'h0);
    xfer(1'b1, 1'b0, 8'hFC, 32'h0);

    // aborted write on the one-wait-state instance
    @(negedge clk);
    sel = 1'b0; psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 8'h08; pwdata = 32'h1234;
    @(negedge clk);
    penable = 1'b1;
    #1 chk("abort_rdy1", {31'b0, rdy}, 32'd0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    #1 chk("abort_rdy2", {31'b0, rdy}, 32'd0);
    xfer(1'b0, 1'b0, 8'h08, 32'h0);

    xfer(1'b0, 1'b1, 8'h04, 32'h11);
    xfer(1'b0, 1'b1, 8'h08, 32'h22);
    xfer(1'b0, 1'b0, 8'h04, 32'h0);
    xfer(1'b0, 1'b0, 8'h08, 32'h0);
    xfer(1'b1, 1'b1, 8'h04, 32'h33);
    xfer(1'b1, 1'b1, 8'h08, 32'h44);
    xfer(1'b1, 1'b0, 8'h04, 32'h0);
    xfer(1'b1, 1'b0, 8'h08, 32'h0);

    // access phase without a setup phase is ignored
    idle();
    @(negedge clk);
    sel = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("nosetup_rdy", {31'b0, rdy}, 32'd0);
      @(negedge clk);
    end
    idle();
    xfer(1'b1, 1'b0, 8'h08, 32'h0);

    // reset in the middle of a write with registers dirty
    @(negedge clk);
    sel = 1'b0; psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 8'h14; pwdata = 32'h55;
    @(negedge clk);
    penable = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("mid_rst_rdy", {31'b0, rdy_a}, 32'd0);
    chk("mid_rst_rd", rd_a, 32'd0);
    @(negedge clk);
    #1;
    chk("mid_rst_rdy2", {31'b0, rdy_a}, 32'd0);
    chk("mid_rst_err", {31'b0, err_a}, 32'd0);
    chk("mid_rst_rd2", rd_a, 32'd0);
    idle();
    rst_n = 1'b1;
    clr_model();
    xfer(1'b0, 1'b0, 8'h0C, 32'h0);
    xfer(1'b0, 1'b0, 8'h14, 32'h0);
    xfer(1'b1, 1'b0, 8'h04, 32'h0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
